// File: rtl/syn_ram_pkg.sv
// Shared types and helpers for the syn_ram_dp dual-port RAM.
package syn_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 32;

  function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/syn_ram_clr_fsm.sv
// Clear sequencer for syn_ram_dp: walks a pointer over every word after reset or a clr request.
module syn_ram_clr_fsm
  import syn_ram_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q;

  // Pointer saturates at LAST; only entry into CLEAR rewinds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          if (ptr_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        IDLE: begin
          if (clr) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_we   = (state_q == CLEAR) && !rst;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/syn_ram_dp.sv
// Simple dual-port synchronous RAM with self-clear, write-first bypass and range protection.
// Optional output register stage: define SYN_RAM_OUT_REG_EN.
module syn_ram_dp
  import syn_ram_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] din,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] dout,
  output logic              r_valid,
  output logic              busy
);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  syn_ram_clr_fsm #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic [DATA_W-1:0] mem [DEPTH];

  logic accept, wr_hit, rd_go;
  // clr wins over any access presented in the same cycle.
  assign accept = !busy && !rst && !clr;
  assign wr_hit = accept && w_en && addr_ok(32'(w_addr), DEPTH);
  assign rd_go  = accept && r_en;

  always_ff @(posedge clk) begin
    if (clr_we)
      mem[clr_addr] <= '0;
    else if (wr_hit)
      mem[w_addr] <= din;
  end

  logic [DATA_W-1:0] dout_d, dout_q;
  logic              r_valid_d, r_valid_q;

  always_comb begin
    dout_d    = dout_q;
    r_valid_d = 1'b0;
    if (rd_go) begin
      r_valid_d = 1'b1;
      if (!addr_ok(32'(r_addr), DEPTH))
        dout_d = '0;
      else if (wr_hit && (w_addr == r_addr))
        dout_d = din;
      else
        dout_d = mem[r_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q    <= '0;
      r_valid_q <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      r_valid_q <= r_valid_d;
    end
  end

`ifdef SYN_RAM_OUT_REG_EN
  logic [DATA_W-1:0] dout_p_q;
  logic              r_valid_p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p_q    <= '0;
      r_valid_p_q <= 1'b0;
    end else begin
      dout_p_q    <= dout_q;
      r_valid_p_q <= r_valid_q;
    end
  end

  assign dout    = dout_p_q;
  assign r_valid = r_valid_p_q;
`else
  assign dout    = dout_q;
  assign r_valid = r_valid_q;
`endif

endmodule

// File: tb/tb_syn_ram_dp.sv
// Directed bench for syn_ram_dp: a DEPTH=32 and a DEPTH=20 instance share one stimulus stream.
module tb_syn_ram_dp;

`ifdef SYN_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [4:0] w_addr = '0;
  logic [4:0] r_addr = '0;
  logic [7:0] din = '0;

  logic [7:0] dout32, dout20;
  logic       rv32, rv20, busy32, busy20;

  syn_ram_dp #(.DATA_W(8), .DEPTH(32)) u32 (
    .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .w_addr(w_addr), .din(din),
    .r_en(r_en), .r_addr(r_addr), .dout(dout32), .r_valid(rv32), .busy(busy32)
  );

  syn_ram_dp #(.DATA_W(8), .DEPTH(20)) u20 (
    .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .w_addr(w_addr), .din(din),
    .r_en(r_en), .r_addr(r_addr), .dout(dout20), .r_valid(rv20), .busy(busy20)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int we; int wa; int d; int re; int ra;
    int ev; int e32; int e20;
  } vec_t;

  vec_t tbl [17] = '{
    '{1,  1,  10, 0,  0, 0,   0,   0},
    '{1,  2,  25, 0,  0, 0,   0,   0},
    '{0,  0,   0, 1,  1, 1,  10,  10},
    '{0,  0,   0, 1,  2, 1,  25,  25},
    '{0,  0,   0, 1,  5, 1,   0,   0},
    '{1,  3,  12, 1,  3, 1,  12,  12},
    '{0,  0,   0, 1,  3, 1,  12,  12},
    '{1, 25,  26, 0,  0, 0,  12,  12},
    '{0,  0,   0, 1, 25, 1,  26,   0},
    '{0,  0,   0, 1,  4, 1,   0,   0},
    '{0,  0,   0, 1,  5, 1,   0,   0},
    '{1,  7, 170, 1, 19, 1,   0,   0},
    '{0,  0,   0, 1,  7, 1, 170, 170},
    '{1, 31,  90, 1, 31, 1,  90,   0},
    '{0,  0,   0, 1, 20, 1,   0,   0},
    '{0,  0,   0, 0,  0, 0,   0,   0},
    '{0,  0,   0, 1, 31, 1,  90,   0}
  };

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (LAT - 1) step();
  endtask

  // Counts edges until each instance drops busy; optionally hammers both ports while clearing.
  task automatic wait_idle(input bit junk, output int n32, output int n20);
    bit vseen;
    n32 = 0; n20 = 0; vseen = 1'b0;
    w_addr = '0; r_addr = '0; din = 8'h33;
    w_en = junk; r_en = junk;
    for (int i = 1; i <= 200 && (n32 == 0 || n20 == 0); i++) begin
      step();
      if (rv32 || rv20) vseen = 1'b1;
      if (!busy32 && n32 == 0) n32 = i;
      if (!busy20 && n20 == 0) n20 = i;
      w_en = junk && busy20;
      r_en = junk && busy20;
    end
    w_en = 1'b0; r_en = 1'b0; din = '0;
    chk("rvalid_during_clear", int'(vseen), 0);
  endtask

  task automatic rd(input int a, output int d32, output int d20);
    r_addr = 5'(a); r_en = 1'b1;
    step();
    r_en = 1'b0;
    settle();
    d32 = int'(dout32);
    d20 = int'(dout20);
  endtask

  initial begin
    int n32, n20, d32, d20;

    step(); step();
    chk("reset_busy32", int'(busy32), 1);
    chk("reset_busy20", int'(busy20), 1);
    chk("reset_dout32", int'(dout32), 0);
    chk("reset_dout20", int'(dout20), 0);
    chk("reset_rvalid32", int'(rv32), 0);
    chk("reset_rvalid20", int'(rv20), 0);

    rst = 1'b0;
    wait_idle(1'b0, n32, n20);
    chk("rst_clear_len32", n32, 32);
    chk("rst_clear_len20", n20, 20);

    for (int i = 0; i < 17; i++) begin
      w_en = tbl[i].we[0]; w_addr = 5'(tbl[i].wa); din = 8'(tbl[i].d);
      r_en = tbl[i].re[0]; r_addr = 5'(tbl[i].ra);
      step();
      w_en = 1'b0; r_en = 1'b0;
      settle();
      chk($sformatf("vec%0d_rvalid32", i), int'(rv32), tbl[i].ev);
      chk($sformatf("vec%0d_rvalid20", i), int'(rv20), tbl[i].ev);
      chk($sformatf("vec%0d_dout32", i), int'(dout32), tbl[i].e32);
      chk($sformatf("vec%0d_dout20", i), int'(dout20), tbl[i].e20);
    end

    // clr with a same-cycle write and read: both accesses must be dropped.
    clr = 1'b1; w_en = 1'b1; w_addr = 5'd9; din = 8'h77; r_en = 1'b1; r_addr = 5'd1;
    step();
    clr = 1'b0; w_en = 1'b0; r_en = 1'b0;
    chk("clr_busy32", int'(busy32), 1);
    chk("clr_busy20", int'(busy20), 1);
    chk("clr_drops_read", int'(rv32 | rv20), 0);
    wait_idle(1'b1, n32, n20);
    chk("clr_len32", n32, 32);
    chk("clr_len20", n20, 20);
    rd(7, d32, d20);  chk("after_clr_rd7_32", d32, 0); chk("after_clr_rd7_20", d20, 0);
    rd(0, d32, d20);  chk("junk_wr_ignored_32", d32, 0); chk("junk_wr_ignored_20", d20, 0);
    rd(1, d32, d20);  chk("after_clr_rd1_32", d32, 0);
    rd(31, d32, d20); chk("after_clr_rd31_32", d32, 0);

    // Second clr mid-clear is ignored.
    clr = 1'b1; step(); clr = 1'b0;
    repeat (5) step();
    clr = 1'b1; step(); clr = 1'b0;
    wait_idle(1'b0, n32, n20);
    chk("clr_in_clear_ignored32", n32, 26);
    chk("clr_in_clear_ignored20", n20, 14);

    // rst mid-clear restarts the full sweep.
    clr = 1'b1; step(); clr = 1'b0;
    repeat (10) step();
    rst = 1'b1; step(); rst = 1'b0;
    wait_idle(1'b0, n32, n20);
    chk("rst_mid_clear_len32", n32, 32);
    chk("rst_mid_clear_len20", n20, 20);

    // Read latency: 26 @4.
    w_en = 1'b1; w_addr = 5'd4; din = 8'd26; step(); w_en = 1'b0;
    r_en = 1'b1; r_addr = 5'd4; step(); r_en = 1'b0;
    chk("lat_edge1_rvalid", int'(rv32), (LAT == 1) ? 1 : 0);
    step();
    chk("lat_edge2_rvalid", int'(rv32), (LAT == 2) ? 1 : 0);
    chk("lat_dout32", int'(dout32), 26);
    chk("lat_dout20", int'(dout20), 26);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
